sm3_inpt_arb: RTL

- Round-robin message arbiter that shares one sm3_pad_core + sm3_expnd_core (+ compression) datapath between CH_NUM message sources.
- The grant is held for a whole message, from the first beat through the beat carrying lst.
- After the last beat, the arbiter blocks all channels until the downstream hash signals completion, because the core processes one message at a time.
- It sits directly in front of the pad core's msg_inpt_* interface and tags the active message with its source id.

---
 rtl/sm3_arb_pkg.sv | 43 ++++
 rtl/sm3_rr_pick.sv | 37 +++
 rtl/sm3_inpt_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sm3_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm3_arb_pkg
// Brief    : Shared types, widths and beat-legality helper for the SM3 input arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sm3_arb_pkg;

`ifdef SM3_INPT_DW_64
    localparam int SM3_INPT_DW = 64;
`else
    localparam int SM3_INPT_DW = 32;
`endif

    localparam int SM3_CH_NUM    = 4;
    localparam int SM3_MAX_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_XFER      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    // True when the low nb bits of vb are a non-zero run of ones starting at the MSB.
    function automatic logic vld_byte_ok(input logic [SM3_MAX_BYTES-1:0] vb, input int nb);
        logic [SM3_MAX_BYTES-1:0] w_al;
        logic                     w_seen_zero;
        logic                     w_ok;
        w_al        = vb << (SM3_MAX_BYTES - nb);
        w_seen_zero = 1'b0;
        w_ok        = w_al[SM3_MAX_BYTES-1];
        for (int i = SM3_MAX_BYTES - 1; i >= 0; i--) begin
            if (!w_al[i]) begin
                w_seen_zero = 1'b1;
            end else if (w_seen_zero) begin
                w_ok = 1'b0;
            end
        end
        return w_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm3_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : sm3_rr_pick
// Brief    : Combinational round-robin priority encoder starting at i_rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module sm3_rr_pick #(
    parameter int CH_NUM = 4,
    parameter int CH_IDW = $clog2(CH_NUM)
) (
    input  logic [CH_NUM-1:0] i_req,
    input  logic [CH_IDW-1:0] i_rr_ptr,
    output logic [CH_IDW-1:0] o_gnt_id,
    output logic              o_gnt_any
);

    logic [CH_IDW:0] w_sum;

    // Walk from the farthest candidate back to i_rr_ptr so the nearest request wins.
    always_comb begin
        o_gnt_id  = '0;
        o_gnt_any = 1'b0;
        w_sum     = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + (CH_IDW + 1)'(k);
            if (w_sum >= (CH_IDW + 1)'(CH_NUM)) begin
                w_sum = w_sum - (CH_IDW + 1)'(CH_NUM);
            end
            if (i_req[w_sum[CH_IDW-1:0]]) begin
                o_gnt_id  = w_sum[CH_IDW-1:0];
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm3_inpt_arb.sv
`default_nettype none
// ============================================================================
// Module   : sm3_inpt_arb
// Brief    : Message-granular round-robin arbiter in front of the SM3 pad core.
// Revision : 1.0 - initial release
// ============================================================================
module sm3_inpt_arb
    import sm3_arb_pkg::*;
#(
    parameter int CH_NUM  = SM3_CH_NUM,
    parameter int INPT_DW = SM3_INPT_DW,
    parameter int CH_IDW  = $clog2(CH_NUM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CH_NUM-1:0]               i_ch_inpt_vld,
    input  logic [CH_NUM-1:0]               i_ch_inpt_lst,
    input  logic [CH_NUM*INPT_DW-1:0]       i_ch_inpt_d,
    input  logic [CH_NUM*(INPT_DW/8)-1:0]   i_ch_inpt_vld_byte,
    output logic [CH_NUM-1:0]               o_ch_inpt_rdy,
    output logic                            o_msg_inpt_vld,
    output logic                            o_msg_inpt_lst,
    output logic [INPT_DW-1:0]              o_msg_inpt_d,
    output logic [INPT_DW/8-1:0]            o_msg_inpt_vld_byte,
    input  logic                            i_msg_inpt_rdy,
    input  logic                            i_cmprss_done,
    output logic [CH_IDW-1:0]               o_msg_src_id,
    output logic                            o_arb_busy,
    output logic [31:0]                     o_msg_beat_cnt,
    output logic                            o_err_vld_byte
);

    localparam int c_BYTE_W = INPT_DW / 8;

    arb_state_t          r_state;
    logic [CH_IDW-1:0]   r_rr_ptr;
    logic [CH_IDW-1:0]   r_src_id;
    logic [31:0]         r_beat_cnt;
    logic                r_busy;
    logic                r_err;

    logic                w_xfer;
    logic                w_gnt_any;
    logic [CH_IDW-1:0]   w_gnt_id;
    logic [CH_IDW-1:0]   w_rr_next;
    logic                w_sel_vld;
    logic                w_sel_lst;
    logic [INPT_DW-1:0]  w_sel_d;
    logic [c_BYTE_W-1:0] w_sel_vb;
    logic [CH_NUM-1:0]   w_rdy;
    logic                w_acc;
    logic                w_bad;

    sm3_rr_pick #(
        .CH_NUM (CH_NUM),
        .CH_IDW (CH_IDW)
    ) u_rr_pick (
        .i_req     (i_ch_inpt_vld),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    assign w_xfer = (r_state == ST_XFER);

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_lst = 1'b0;
        w_sel_d   = '0;
        w_sel_vb  = '0;
        w_rdy     = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (r_src_id == CH_IDW'(i)) begin
                w_sel_vld = i_ch_inpt_vld[i];
                w_sel_lst = i_ch_inpt_lst[i];
                w_sel_d   = i_ch_inpt_d[i*INPT_DW +: INPT_DW];
                w_sel_vb  = i_ch_inpt_vld_byte[i*c_BYTE_W +: c_BYTE_W];
                w_rdy[i]  = w_xfer & i_msg_inpt_rdy;
            end
        end
    end

    // Everything downstream is forced to zero outside XFER so the pad core sees clean idles.
    assign o_ch_inpt_rdy       = w_rdy;
    assign o_msg_inpt_vld      = w_xfer & w_sel_vld;
    assign o_msg_inpt_lst      = w_xfer & w_sel_lst;
    assign o_msg_inpt_d        = w_xfer ? w_sel_d  : '0;
    assign o_msg_inpt_vld_byte = w_xfer ? w_sel_vb : '0;

    assign w_acc = o_msg_inpt_vld & i_msg_inpt_rdy;
    assign w_bad = ~vld_byte_ok(SM3_MAX_BYTES'(w_sel_vb), c_BYTE_W)
                 | (~w_sel_lst & (w_sel_vb != {c_BYTE_W{1'b1}}));

    assign w_rr_next = (r_src_id == CH_IDW'(CH_NUM - 1)) ? '0 : r_src_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_src_id   <= '0;
            r_beat_cnt <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        r_src_id   <= w_gnt_id;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_acc) begin
                        if (r_beat_cnt != 32'hFFFF_FFFF) begin
                            r_beat_cnt <= r_beat_cnt + 32'd1;
                        end
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end
                        if (w_sel_lst) begin
                            r_state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_cmprss_done) begin
                        r_rr_ptr <= w_rr_next;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_msg_src_id   = r_src_id;
    assign o_arb_busy     = r_busy;
    assign o_msg_beat_cnt = r_beat_cnt;
    assign o_err_vld_byte = r_err;

endmodule
`default_nettype wire
